// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap sequencer. It captures mepc/mcause/mtval/mstatus on a trap or mret,
// runs a FLUSH then a REDIRECT cycle, and redirects fetch to mtvec or mepc.
// Latency: an event sampled at edge N gives flush in N+1 and redirect in N+2, and RUN resumes at N+3.
// Backpressure: while busy, stall holds fetch/decode, and new events and CSR writes are ignored.
// Ports: clk/reset; commit inputs instr_valid, exc_code, exc_pc, exc_tval, mret_valid and irq;
//        CSR port csr_we, csr_addr, csr_wdata and csr_rdata (the read is combinational);
//        sequencing outputs flush, stall, redirect_valid, redirect_pc and trap_busy.
module trap_unit #(
  parameter int               XLEN        = 64,
  parameter logic [5:0]       NONE_CODE   = 6'h1F,
  parameter logic [XLEN-1:0]  RESET_MTVEC = 64'h0000_0000_0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            irq,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [5:0]  IRQ_CODE     = 6'd11;

  // mtvec is direct mode only, and mepc is always halfword aligned.
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_REDIRECT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            mcause_irq_q, mcause_irq_d;
  logic [5:0]      mcause_code_q, mcause_code_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // Event decode in priority order: exception, then mret, then interrupt.
  logic exc_take, mret_take, irq_take, evt_take;
  assign exc_take  = instr_valid && (exc_code != NONE_CODE);
  assign mret_take = instr_valid && mret_valid && !exc_take;
  assign irq_take  = instr_valid && irq && mie_q && !exc_take && !mret_valid;
  assign evt_take  = exc_take || mret_take || irq_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      mtvec_q       <= RESET_MTVEC & MTVEC_MASK;
      mepc_q        <= '0;
      mtval_q       <= '0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      target_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mtval_q       <= mtval_d;
      mcause_irq_q  <= mcause_irq_d;
      mcause_code_q <= mcause_code_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mtval_d        = mtval_q;
    mcause_irq_d   = mcause_irq_q;
    mcause_code_d  = mcause_code_q;
    mie_d          = mie_q;
    mpie_d         = mpie_q;
    target_d       = target_q;
    redirect_pc_d  = redirect_pc_q;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    trap_busy      = 1'b0;

    case (state_q)
      S_RUN: begin
        // A taken event owns the trap CSRs this cycle. An mtvec write still
        // lands, but the trap below uses the pre-write mtvec_q.
        if (csr_we) begin
          case (csr_addr)
            ADDR_MTVEC: mtvec_d = csr_wdata & MTVEC_MASK;
            ADDR_MSTATUS: if (!evt_take) begin
              mie_d  = csr_wdata[3];
              mpie_d = csr_wdata[7];
            end
            ADDR_MEPC: if (!evt_take) mepc_d = csr_wdata & MEPC_MASK;
            ADDR_MCAUSE: if (!evt_take) begin
              mcause_irq_d  = csr_wdata[XLEN-1];
              mcause_code_d = csr_wdata[5:0];
            end
            ADDR_MTVAL: if (!evt_take) mtval_d = csr_wdata;
            default: ;
          endcase
        end
        if (exc_take) begin
          mepc_d        = exc_pc & MEPC_MASK;
          mcause_irq_d  = 1'b0;
          mcause_code_d = exc_code;
          mtval_d       = exc_tval;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          target_d      = mtvec_q;
          state_d       = S_FLUSH;
        end else if (mret_take) begin
          mie_d    = mpie_q;
          mpie_d   = 1'b1;
          target_d = mepc_q;
          state_d  = S_FLUSH;
        end else if (irq_take) begin
          mepc_d        = exc_pc & MEPC_MASK;
          mcause_irq_d  = 1'b1;
          mcause_code_d = IRQ_CODE;
          mtval_d       = '0;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          target_d      = mtvec_q;
          state_d       = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush         = 1'b1;
        stall         = 1'b1;
        trap_busy     = 1'b1;
        redirect_pc_d = target_q;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        trap_busy      = 1'b1;
        state_d        = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // redirect_pc is loaded entering REDIRECT and holds its value afterwards.
  assign redirect_pc = redirect_pc_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = mie_q;
        csr_rdata[7] = mpie_q;
      end
      ADDR_MTVEC:  csr_rdata = mtvec_q;
      ADDR_MEPC:   csr_rdata = mepc_q;
      ADDR_MCAUSE: csr_rdata = {mcause_irq_q, {(XLEN-7){1'b0}}, mcause_code_q};
      ADDR_MTVAL:  csr_rdata = mtval_q;
      default:     csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// Testbench for trap_unit. It runs directed steps, then random commit traffic, against a reference model.
// The model records what each trap or mret does and queues the FLUSH and REDIRECT cycles that should follow.
module tb_trap_unit;
  localparam logic [5:0] NONE = 6'h1F;

  logic        clk = 1'b0;
  logic        reset, instr_valid, mret_valid, irq, csr_we;
  logic [5:0]  exc_code;
  logic [63:0] exc_pc, exc_tval, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic        flush, stall, redirect_valid, trap_busy;

  always #5 clk = ~clk;

  trap_unit dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid), .irq(irq),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_busy(trap_busy)
  );

  // Reference model state.
  typedef struct { logic fl; logic rv; logic [63:0] pc; } exp_t;
  exp_t        q[$];
  exp_t        cur;
  logic [63:0] m_mtvec, m_mepc, m_mtval, m_rpc;
  logic        m_cirq, m_mie, m_mpie;
  logic [5:0]  m_ccode;
  int          passed = 0, total = 0, rv_seen = 0;

  function automatic logic [63:0] m_read(input logic [11:0] a);
    logic [63:0] r;
    r = '0;
    case (a)
      12'h300: begin r[3] = m_mie; r[7] = m_mpie; end
      12'h305: r = m_mtvec & ~64'h3;
      12'h341: r = m_mepc & ~64'h1;
      12'h342: r = {m_cirq, 57'b0, m_ccode};
      12'h343: r = m_mtval;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    cur = '{fl: 1'b0, rv: 1'b0, pc: 64'h0};
    m_mtvec = 64'h100; m_mepc = 0; m_mtval = 0; m_rpc = 0;
    m_cirq = 0; m_ccode = 0; m_mie = 0; m_mpie = 0;
  endtask

  // Apply the model's rules to the current inputs, clock once, then compare all outputs.
  task automatic cycle();
    logic        exc, mr, it;
    logic [63:0] o_mtvec, o_mepc, o_mtval;
    logic        o_cirq, o_mie, o_mpie;
    logic [5:0]  o_ccode;
    if (reset) model_reset();
    else if (!cur.fl && !cur.rv) begin
      exc = instr_valid && exc_code != NONE;
      mr  = instr_valid && mret_valid && !exc;
      it  = instr_valid && irq && m_mie && !exc && !mret_valid;
      o_mtvec = m_mtvec; o_mepc = m_mepc; o_mtval = m_mtval;
      o_cirq = m_cirq; o_ccode = m_ccode; o_mie = m_mie; o_mpie = m_mpie;
      if (csr_we) begin
        case (csr_addr)
          12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
          12'h305: m_mtvec = csr_wdata;
          12'h341: m_mepc = csr_wdata;
          12'h342: begin m_cirq = csr_wdata[63]; m_ccode = csr_wdata[5:0]; end
          12'h343: m_mtval = csr_wdata;
          default: ;
        endcase
      end
      if (exc || mr || it) begin
        // The event owns the trap CSRs, so any same-cycle software write to them is dropped.
        m_mepc = o_mepc; m_mtval = o_mtval; m_cirq = o_cirq; m_ccode = o_ccode;
        m_mie = o_mie; m_mpie = o_mpie;
        if (mr) begin
          m_mie = o_mpie; m_mpie = 1'b1;
          q.push_back('{fl: 1'b1, rv: 1'b0, pc: 64'h0});
          q.push_back('{fl: 1'b0, rv: 1'b1, pc: o_mepc & ~64'h1});
        end else begin
          m_mepc = exc_pc;
          m_cirq = it;
          m_ccode = exc ? exc_code : 6'd11;
          m_mtval = exc ? exc_tval : 64'h0;
          m_mpie = o_mie; m_mie = 1'b0;
          q.push_back('{fl: 1'b1, rv: 1'b0, pc: 64'h0});
          q.push_back('{fl: 1'b0, rv: 1'b1, pc: o_mtvec & ~64'h3});
        end
      end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{fl: 1'b0, rv: 1'b0, pc: 64'h0};
      if (cur.rv) m_rpc = cur.pc;
    end
    if (redirect_valid) rv_seen = rv_seen + 1;
    chk("flush", 64'(flush), 64'(cur.fl));
    chk("redirect_valid", 64'(redirect_valid), 64'(cur.rv));
    chk("stall", 64'(stall), 64'(cur.fl | cur.rv));
    chk("trap_busy", 64'(trap_busy), 64'(cur.fl | cur.rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("csr_rdata_model", csr_rdata, m_read(csr_addr));
  endtask

  task automatic idle_in();
    reset = 0; instr_valid = 0; exc_code = NONE; mret_valid = 0; irq = 0;
    csr_we = 0; exc_pc = 0; exc_tval = 0; csr_wdata = 0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    model_reset();
    idle_in();
    csr_addr = 12'h300;
    // Reset, then read back every CSR.
    reset = 1; cycle(); cycle(); reset = 0;
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_busy", 64'(trap_busy), 64'h0);
    rd("rst_mtvec", 12'h305, 64'h100);
    rd("rst_mstatus", 12'h300, 64'h0);
    rd("rst_mepc", 12'h341, 64'h0);
    rd("rst_mcause", 12'h342, 64'h0);
    rd("rst_mtval", 12'h343, 64'h0);

    // Illegal instruction: flush in N+1, redirect to mtvec in N+2.
    instr_valid = 1; exc_code = 6'd2; exc_pc = 64'h2000; exc_tval = 64'hDEADBEEF;
    cycle();
    chk("ill_flush", 64'(flush), 64'h1);
    idle_in(); cycle();
    chk("ill_rv", 64'(redirect_valid), 64'h1);
    chk("ill_rpc", redirect_pc, 64'h100);
    cycle();
    rd("ill_mepc", 12'h341, 64'h2000);
    rd("ill_mcause", 12'h342, 64'h2);
    rd("ill_mtval", 12'h343, 64'hDEADBEEF);
    rd("ill_mstatus", 12'h300, 64'h0);

    // Enable MIE, take an interrupt, then return with mret.
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 64'h8; cycle(); idle_in();
    instr_valid = 1; irq = 1; exc_pc = 64'h3004; cycle();
    idle_in(); cycle(); cycle();
    rd("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd("irq_mepc", 12'h341, 64'h3004);
    rd("irq_mstatus", 12'h300, 64'h80);
    instr_valid = 1; mret_valid = 1; cycle();
    idle_in(); cycle();
    chk("mret_rpc", redirect_pc, 64'h3004);
    cycle();
    rd("mret_mstatus", 12'h300, 64'h88);

    // An exception and an mret in the same cycle: the exception wins.
    instr_valid = 1; exc_code = 6'hB; mret_valid = 1; exc_pc = 64'h4000; cycle();
    idle_in(); cycle();
    chk("excmret_rpc", redirect_pc, 64'h100);
    cycle();
    rd("excmret_mcause", 12'h342, 64'hB);

    // A new exception that arrives while a trap is in flight is ignored.
    rv_seen = 0;
    instr_valid = 1; exc_code = 6'd3; exc_pc = 64'h5000; cycle();
    exc_code = 6'd5; exc_pc = 64'h5100; cycle(); cycle();
    idle_in(); cycle();
    rd("inflight_mcause", 12'h342, 64'h3);
    chk("inflight_pulses", 64'(rv_seen), 64'h1);

    // An mtvec write in the same cycle as an exception: the trap uses the old mtvec.
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 64'h403;
    instr_valid = 1; exc_code = 6'd4; exc_pc = 64'h6000; cycle();
    idle_in(); cycle();
    chk("mtvecw_rpc", redirect_pc, 64'h100);
    cycle();
    rd("mtvecw_mtvec", 12'h305, 64'h400);

    // Reset asserted during FLUSH aborts the sequence.
    rv_seen = 0;
    instr_valid = 1; exc_code = 6'd2; exc_pc = 64'h7000; cycle();
    idle_in(); reset = 1; cycle();
    chk("rstfl_busy", 64'(trap_busy), 64'h0);
    reset = 0; cycle(); cycle();
    chk("rstfl_pulses", 64'(rv_seen), 64'h0);
    chk("rstfl_rpc", redirect_pc, 64'h0);

    // Random commit traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [11:0] addrs[6];
      addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};
      reset       = ($urandom_range(0, 99) == 0);
      instr_valid = $urandom_range(0, 1);
      exc_code    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : NONE;
      mret_valid  = ($urandom_range(0, 7) == 0);
      irq         = ($urandom_range(0, 3) == 0);
      csr_we      = ($urandom_range(0, 5) == 0);
      csr_addr    = addrs[$urandom_range(0, 5)];
      csr_wdata   = {$urandom, $urandom};
      exc_pc      = {$urandom, $urandom};
      exc_tval    = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Machine-mode trap sequencer that sits directly downstream of the exception cause encoder.
- Consumes the 6-bit cause code of the retiring instruction, plus mret and an external interrupt line.
- Captures the trap CSRs (mepc, mcause, mtval, mstatus.MIE/MPIE) and holds mtvec.
- Runs a 3-state sequence that flushes the pipeline and redirects fetch to the trap vector or to mepc.

Parameters:
- XLEN, 64, data/address width of the CSRs and PCs.
- NONE_CODE, 6'h1F, cause value meaning "no exception".
- RESET_MTVEC, 64'h0000_0000_0000_0100, reset value of mtvec.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  a valid instruction is at the commit point this cycle.
- exc_code  input  6  cause from the exception encoder; NONE_CODE means no exception.
- exc_pc  input  XLEN  PC of the committing instruction.
- exc_tval  input  XLEN  faulting address or instruction bits.
- mret_valid  input  1  the committing instruction is mret.
- irq  input  1  level-sensitive machine external interrupt request.
- csr_we  input  1  CSR write strobe.
- csr_addr  input  12  CSR address, for both read and write.
- csr_wdata  input  XLEN  CSR write data.
- csr_rdata  output  XLEN  combinational CSR read data.
- flush  output  1  kill all in-flight instructions.
- stall  output  1  hold fetch/decode.
- redirect_valid  output  1  fetch must load redirect_pc.
- redirect_pc  output  XLEN  redirect target.
- trap_busy  output  1  high whenever the state is not RUN.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset state:
  - State = RUN.
  - mtvec = RESET_MTVEC with bits [1:0] forced to 0.
  - mepc, mcause, mtval, MIE, MPIE = 0.
  - flush, stall, redirect_valid, trap_busy = 0; redirect_pc = 0.
  - Reset asserted during FLUSH or REDIRECT aborts the sequence; no redirect is issued.
- CSR map:
  - mstatus 0x300: bit 3 = MIE, bit 7 = MPIE, all other bits read 0.
  - mtvec 0x305: bits [1:0] read 0, direct mode only.
  - mepc 0x341: bit 0 reads 0.
  - mcause 0x342: bit XLEN-1 = interrupt flag, low 6 bits = code.
  - mtval 0x343.
  - Unmapped addresses read 0 and ignore writes.
- State RUN, events checked in priority order; the first match wins:
  1. Exception: instr_valid & exc_code != NONE_CODE.
     - mepc <= exc_pc; mcause <= {0, zero-extended exc_code}; mtval <= exc_tval.
     - MPIE <= MIE; MIE <= 0; target <= mtvec.
     - Go to FLUSH.
  2. mret: instr_valid & mret_valid.
     - MIE <= MPIE; MPIE <= 1; target <= mepc.
     - Go to FLUSH.
  3. Interrupt: instr_valid & irq & MIE.
     - mepc <= exc_pc (the instruction does not retire); mcause <= {1, 0..0, 6'd11}; mtval <= 0.
     - MPIE <= MIE; MIE <= 0; target <= mtvec.
     - Go to FLUSH.
  4. Otherwise: stay in RUN.
- State FLUSH: flush = 1, stall = 1, trap_busy = 1 for exactly one cycle, then go to REDIRECT.
- State REDIRECT: redirect_valid = 1, redirect_pc = target, stall = 1, trap_busy = 1 for exactly one cycle, then go to RUN.
- Latency: the event is sampled at edge N; flush is high in cycle N+1; redirect is high in cycle N+2; RUN resumes at N+3.
- Outside FLUSH and REDIRECT: flush, stall and redirect_valid are 0; redirect_pc holds its last value.
- Events in FLUSH/REDIRECT: exc_code, mret_valid and irq are ignored (those instructions are being flushed).
- CSR write in RUN:
  - Applied at the clock edge.
  - If a trap or mret is taken in the same cycle, the trap/mret updates to mepc, mcause, mtval and mstatus win.
  - A same-cycle mtvec write is still applied; the trap uses the pre-write mtvec.
- CSR writes during FLUSH/REDIRECT: ignored.
- mret with exc_code != NONE_CODE in the same cycle: the exception wins; mret has no effect.
- irq with MIE = 0: ignored; irq stays pending (level) until software sets MIE.

Test Plan:
- Reset, then read all five CSRs -> mtvec = 0x100, all others 0; flush = redirect_valid = trap_busy = 0.
- Illegal instruction: exc_code = 2, exc_pc = 0x2000, exc_tval = 0xDEADBEEF -> flush at N+1, redirect_pc = 0x100 at N+2; mepc = 0x2000, mcause = 2, mtval = 0xDEADBEEF, MIE = 0.
- Set MIE = 1, assert irq at exc_pc = 0x3004 -> mcause = 0x8000_0000_0000_000B, mepc = 0x3004, MPIE = 1, MIE = 0; then mret -> redirect_pc = 0x3004, MIE = 1, MPIE = 1.
- Same cycle: exc_code = 0xB and mret_valid = 1 -> exception taken; mcause = 0xB; redirect to mtvec, not mepc.
- Trap in flight: exc_code = 5 arriving during FLUSH and REDIRECT -> ignored; mcause unchanged; exactly one redirect pulse.
- Same cycle: csr_we to mtvec = 0x403 and an exception -> redirect_pc = old mtvec; mtvec reads 0x400 afterwards.
- Reset asserted during FLUSH -> no redirect_valid pulse; state RUN and all outputs 0 the next cycle.
